riscv_memarb: RTL and testbench

Two-requester memory arbiter sharing one BIU port between the instruction-fetch path and the data-memory path. It sits between the two CPU-side access buffers and the single bus interface unit. It grants one requester at a time, tags every accepted request with its owner, and routes in-order responses back to the correct requester.

---
 rtl/biu_constants_pkg.sv | 15 +
 rtl/rl_queue.sv | 83 ++++++++
 rtl/riscv_memarb.sv | 149 ++++++++++++++
 tb/tb_riscv_memarb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - shared BIU size encoding and owner tags
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/rl_queue.sv
// rtl/rl_queue.sv - small synchronous FIFO with count-based full/empty flags
module rl_queue #(
  parameter int DEPTH = 2,
  parameter int DBITS = 1
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] d_i,
  input  logic             re_i,
  output logic [DBITS-1:0] q_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  assign empty_o        = (cnt_q == '0);
  assign full_o         = (cnt_q == CW'(DEPTH));
  assign almost_empty_o = (cnt_q <= CW'(1));
  assign almost_full_o  = (cnt_q >= CW'(DEPTH - 1));
  assign q_o            = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so full accepts a push alongside a pop
  assign do_pop  = re_i & ~empty_o;
  assign do_push = we_i & (~full_o | do_pop);

  // Next pointers, occupancy and storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = d_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_memarb.sv
// rtl/riscv_memarb.sv - fetch/data arbiter onto a single BIU port with in-order response routing
module riscv_memarb
  import biu_constants_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  input  biu_size_t       if_size_i,
  output logic            if_stb_ack_o,
  output logic            if_d_ack_o,
  output logic            if_err_o,
  output logic [XLEN-1:0] if_q_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic            dm_lock_i,
  input  logic [XLEN-1:0] dm_adr_i,
  input  biu_size_t       dm_size_i,
  input  logic [XLEN-1:0] dm_d_i,
  output logic            dm_stb_ack_o,
  output logic            dm_d_ack_o,
  output logic            dm_err_o,
  output logic [XLEN-1:0] dm_q_o,
  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  output logic            biu_we_o,
  output logic            biu_lock_o,
  output logic [XLEN-1:0] biu_adr_o,
  output logic [XLEN-1:0] biu_d_o,
  output biu_size_t       biu_size_o,
  input  logic            biu_d_ack_i,
  input  logic            biu_err_i,
  input  logic [XLEN-1:0] biu_q_i
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_DM} arb_state_t;

  arb_state_t state_q, state_d;
  logic       lock_held_q, lock_held_d;
  logic       owner_full, owner_empty, owner_head;
  logic       beat, grant_owner;

  assign beat        = biu_stb_o & biu_stb_ack_i;
  assign grant_owner = (state_q == ARB_DM) ? OWNER_DM : OWNER_IF;

  // Strobe and request muxing from the currently granted port
  always_comb begin
    biu_stb_o  = 1'b0;
    biu_we_o   = 1'b0;
    biu_lock_o = 1'b0;
    biu_adr_o  = '0;
    biu_d_o    = '0;
    biu_size_o = BYTE;
    case (state_q)
      ARB_IF: begin
        biu_stb_o  = if_req_i & ~owner_full & ~clr_i;
        biu_adr_o  = if_adr_i;
        biu_size_o = if_size_i;
      end
      ARB_DM: begin
        biu_stb_o  = dm_req_i & ~owner_full & ~clr_i;
        biu_we_o   = dm_we_i;
        biu_lock_o = dm_lock_i;
        biu_adr_o  = dm_adr_i;
        biu_d_o    = dm_d_i;
        biu_size_o = dm_size_i;
      end
      default: ;
    endcase
  end

  assign if_stb_ack_o = beat & (state_q == ARB_IF);
  assign dm_stb_ack_o = beat & (state_q == ARB_DM);

  // Responses follow the head of the owner queue; stray acks on an empty queue vanish
  assign if_d_ack_o = biu_d_ack_i & ~owner_empty & (owner_head == OWNER_IF);
  assign dm_d_ack_o = biu_d_ack_i & ~owner_empty & (owner_head == OWNER_DM);
  assign if_err_o   = biu_err_i   & ~owner_empty & (owner_head == OWNER_IF);
  assign dm_err_o   = biu_err_i   & ~owner_empty & (owner_head == OWNER_DM);
  assign if_q_o     = biu_q_i;
  assign dm_q_o     = biu_q_i;

  // Grant selection: data wins from idle, grants alternate per beat, a lock pins data
  always_comb begin
    state_d     = state_q;
    lock_held_d = lock_held_q;
    if (clr_i) begin
      state_d     = ARB_IDLE;
      lock_held_d = 1'b0;
    end else begin
      if ((state_q == ARB_DM) && beat && dm_lock_i) lock_held_d = 1'b1;
      else if (lock_held_q && !dm_lock_i && owner_empty) lock_held_d = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (dm_req_i)      state_d = ARB_DM;
          else if (if_req_i) state_d = ARB_IF;
        end
        ARB_IF: begin
          if (beat && dm_req_i) state_d = ARB_DM;
          else if (if_req_i)    state_d = ARB_IF;
          else if (dm_req_i)    state_d = ARB_DM;
          else                  state_d = ARB_IDLE;
        end
        ARB_DM: begin
          if (lock_held_d)           state_d = ARB_DM;
          else if (beat && if_req_i) state_d = ARB_IF;
          else if (dm_req_i)         state_d = ARB_DM;
          else if (if_req_i)         state_d = ARB_IF;
          else                       state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      lock_held_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_held_q <= lock_held_d;
    end
  end

  // Flush leaves the owner queue intact so in-flight responses still find their owner
  rl_queue #(
    .DEPTH (DEPTH),
    .DBITS (1)
  ) u_owner_q (
    .rst_ni         (rst_ni),
    .clk_i          (clk_i),
    .clr_i          (1'b0),
    .we_i           (beat),
    .d_i            (grant_owner),
    .re_i           (biu_d_ack_i),
    .q_o            (owner_head),
    .empty_o        (owner_empty),
    .full_o         (owner_full),
    .almost_empty_o (),
    .almost_full_o  ()
  );

endmodule

// File: tb/tb_riscv_memarb.sv
// tb/tb_riscv_memarb.sv - directed self-checking bench for riscv_memarb
module tb_riscv_memarb;
  import biu_constants_pkg::*;

  localparam int XLEN = 32;

  logic            rst_ni, clk_i, clr_i;
  logic            if_req_i;
  logic [XLEN-1:0] if_adr_i;
  biu_size_t       if_size_i;
  logic            if_stb_ack_o, if_d_ack_o, if_err_o;
  logic [XLEN-1:0] if_q_o;
  logic            dm_req_i, dm_we_i, dm_lock_i;
  logic [XLEN-1:0] dm_adr_i, dm_d_i;
  biu_size_t       dm_size_i;
  logic            dm_stb_ack_o, dm_d_ack_o, dm_err_o;
  logic [XLEN-1:0] dm_q_o;
  logic            biu_stb_o, biu_stb_ack_i, biu_we_o, biu_lock_o;
  logic [XLEN-1:0] biu_adr_o, biu_d_o;
  biu_size_t       biu_size_o;
  logic            biu_d_ack_i, biu_err_i;
  logic [XLEN-1:0] biu_q_i;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_memarb #(.XLEN(XLEN), .DEPTH(2)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .clr_i(clr_i),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_size_i(if_size_i),
    .if_stb_ack_o(if_stb_ack_o), .if_d_ack_o(if_d_ack_o), .if_err_o(if_err_o), .if_q_o(if_q_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_lock_i(dm_lock_i), .dm_adr_i(dm_adr_i),
    .dm_size_i(dm_size_i), .dm_d_i(dm_d_i),
    .dm_stb_ack_o(dm_stb_ack_o), .dm_d_ack_o(dm_d_ack_o), .dm_err_o(dm_err_o), .dm_q_o(dm_q_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_we_o(biu_we_o),
    .biu_lock_o(biu_lock_o), .biu_adr_o(biu_adr_o), .biu_d_o(biu_d_o), .biu_size_o(biu_size_o),
    .biu_d_ack_i(biu_d_ack_i), .biu_err_i(biu_err_i), .biu_q_i(biu_q_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are checked 1 ns later
  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; clr_i = 1'b0;
    if_req_i = 1'b0; if_adr_i = '0; if_size_i = BYTE;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_lock_i = 1'b0;
    dm_adr_i = '0; dm_size_i = BYTE; dm_d_i = '0;
    biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0;

    // reset state
    cyc(); #1;
    check("rst_stb", biu_stb_o, 0);
    check("rst_if_stb_ack", if_stb_ack_o, 0);
    check("rst_dm_stb_ack", dm_stb_ack_o, 0);
    check("rst_if_d_ack", if_d_ack_o, 0);
    check("rst_dm_d_ack", dm_d_ack_o, 0);
    check("rst_errs", {if_err_o, dm_err_o}, 0);
    check("rst_we_lock", {biu_we_o, biu_lock_o}, 0);
    check("rst_adr", biu_adr_o, 0);
    check("rst_d", biu_d_o, 0);
    check("rst_size", biu_size_o, 0);
    check("rst_q", {if_q_o, dm_q_o}, 0);
    cyc(); rst_ni = 1'b1;

    // spurious response on an empty queue
    cyc(); biu_d_ack_i = 1'b1; biu_err_i = 1'b1; #1;
    check("spur_if_ack", if_d_ack_o, 0);
    check("spur_dm_ack", dm_d_ack_o, 0);
    check("spur_errs", {if_err_o, dm_err_o}, 0);
    cyc(); #1;
    check("spur2_acks", {if_d_ack_o, dm_d_ack_o}, 0);
    biu_d_ack_i = 1'b0; biu_err_i = 1'b0;

    // single fetch: strobe one cycle after req, response routed to fetch
    cyc(); if_req_i = 1'b1; if_adr_i = 32'h100; if_size_i = WORD; biu_stb_ack_i = 1'b1; #1;
    check("if_idle_stb", biu_stb_o, 0);
    cyc(); #1;
    check("if_stb", biu_stb_o, 1);
    check("if_adr", biu_adr_o, 32'h100);
    check("if_size", biu_size_o, 2);
    check("if_we", biu_we_o, 0);
    check("if_stb_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b10);
    cyc(); if_req_i = 1'b0; biu_stb_ack_i = 1'b0;
    biu_d_ack_i = 1'b1; biu_q_i = 32'h12345678; #1;
    check("if_rsp_stb", biu_stb_o, 0);
    check("if_rsp_ack", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    check("if_rsp_q", if_q_o, 32'h12345678);
    cyc(); biu_d_ack_i = 1'b0; biu_q_i = '0; #1;

    // both request: DM first, then alternate; responses follow in order
    cyc(); if_req_i = 1'b1; if_adr_i = 32'h300; dm_req_i = 1'b1; dm_adr_i = 32'h200;
    dm_we_i = 1'b1; dm_d_i = 32'hAAAA; dm_size_i = HWORD; biu_stb_ack_i = 1'b1; #1;
    check("alt0_stb", biu_stb_o, 0);
    cyc(); #1;
    check("alt1_adr", biu_adr_o, 32'h200);
    check("alt1_wd", {biu_we_o, biu_d_o}, {1'b1, 32'hAAAA});
    check("alt1_size", biu_size_o, 1);
    check("alt1_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    cyc(); biu_d_ack_i = 1'b1; #1;
    check("alt2_adr", biu_adr_o, 32'h300);
    check("alt2_wd", {biu_we_o, biu_d_o}, 0);
    check("alt2_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b10);
    check("alt2_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b01);
    cyc(); #1;
    check("alt3_adr", biu_adr_o, 32'h200);
    check("alt3_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    check("alt3_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    cyc(); #1;
    check("alt4_adr", biu_adr_o, 32'h300);
    check("alt4_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b10);
    check("alt4_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b01);
    cyc(); if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0; #1;
    check("alt5_stb", biu_stb_o, 0);
    check("alt5_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    cyc(); #1;
    check("alt6_spur", {if_d_ack_o, dm_d_ack_o}, 0);
    biu_d_ack_i = 1'b0;

    // full owner queue holds the strobe low until a pop
    cyc(); if_req_i = 1'b1; #1;
    cyc(); dm_req_i = 1'b1; #1;
    check("full1_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b10);
    cyc(); if_req_i = 1'b0; #1;
    check("full2_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    cyc(); #1;
    check("full3_stb", biu_stb_o, 0);
    cyc(); biu_d_ack_i = 1'b1; #1;
    check("full4_stb", biu_stb_o, 0);
    check("full4_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    cyc(); biu_d_ack_i = 1'b0; #1;
    check("full5_stb", biu_stb_o, 1);
    check("full5_ack", dm_stb_ack_o, 1);
    cyc(); dm_req_i = 1'b0; biu_d_ack_i = 1'b1; #1;
    check("full6_stb", biu_stb_o, 0);
    check("full6_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b01);
    cyc(); #1;
    check("full7_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b01);
    cyc(); biu_d_ack_i = 1'b0; #1;

    // locked data sequence starves fetch until unlock and drain
    cyc(); if_req_i = 1'b1; dm_req_i = 1'b1; dm_lock_i = 1'b1; #1;
    cyc(); #1;
    check("lk1_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    check("lk1_lock", biu_lock_o, 1);
    cyc(); #1;
    check("lk2_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    cyc(); biu_d_ack_i = 1'b1; #1;
    check("lk3_stb", biu_stb_o, 0);
    check("lk3_lock", biu_lock_o, 1);
    check("lk3_rsp", dm_d_ack_o, 1);
    cyc(); biu_d_ack_i = 1'b0; #1;
    check("lk4_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b01);
    cyc(); dm_lock_i = 1'b0; dm_req_i = 1'b0; biu_d_ack_i = 1'b1; #1;
    check("lk5_stb", biu_stb_o, 0);
    check("lk5_lock", biu_lock_o, 0);
    check("lk5_rsp", dm_d_ack_o, 1);
    cyc(); #1;
    check("lk6_stb", biu_stb_o, 0);
    check("lk6_rsp", dm_d_ack_o, 1);
    cyc(); biu_d_ack_i = 1'b0; #1;
    check("lk7_stb", biu_stb_o, 0);
    cyc(); #1;
    check("lk8_ack", {if_stb_ack_o, dm_stb_ack_o}, 2'b10);
    check("lk8_adr", biu_adr_o, 32'h300);
    cyc(); if_req_i = 1'b0; biu_d_ack_i = 1'b1; #1;
    check("lk9_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    cyc(); biu_d_ack_i = 1'b0; #1;

    // flush with a fetch in flight: strobe blocked, response still reaches fetch
    cyc(); if_req_i = 1'b1; #1;
    cyc(); #1;
    check("fl1_ack", if_stb_ack_o, 1);
    cyc(); clr_i = 1'b1; #1;
    check("fl2_stb", biu_stb_o, 0);
    check("fl2_ack", if_stb_ack_o, 0);
    cyc(); clr_i = 1'b0; biu_d_ack_i = 1'b1; biu_err_i = 1'b1; biu_q_i = 32'hDEADBEEF; #1;
    check("fl3_idle_stb", biu_stb_o, 0);
    check("fl3_rsp", {if_d_ack_o, dm_d_ack_o}, 2'b10);
    check("fl3_err", {if_err_o, dm_err_o}, 2'b10);
    check("fl3_q", if_q_o, 32'hDEADBEEF);
    cyc(); if_req_i = 1'b0; biu_d_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0; #1;

    // asynchronous reset mid-burst discards strobe and owner tags
    cyc(); dm_req_i = 1'b1; #1;
    cyc(); #1;
    check("rb1_stb", biu_stb_o, 1);
    cyc(); #1;
    check("rb2_stb_pre", biu_stb_o, 1);
    rst_ni = 1'b0; #1;
    check("rb2_stb_rst", biu_stb_o, 0);
    check("rb2_ack_rst", dm_stb_ack_o, 0);
    cyc(); rst_ni = 1'b1; dm_req_i = 1'b0; biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b1; #1;
    check("rb3_stb", biu_stb_o, 0);
    check("rb3_rsp", {if_d_ack_o, dm_d_ack_o}, 0);
    cyc(); biu_d_ack_i = 1'b0; #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
